// File: rtl/pwm_ctrl.sv
// Two-channel memory-mapped PWM controller for H-bridge motor drivers.
// Settings are shadowed and applied on period boundaries; direction reversals insert dead time.
module pwm_ctrl #(
    parameter int CNT_W = 16,
    parameter int DEAD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  pwm1out,
    output logic [1:0]  pwm2out
);

    localparam int              DW      = $clog2(DEAD + 1);
    localparam logic [DW-1:0]   DEAD_LD = DW'(DEAD);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] duty;
        logic             dir;
    } chan_cfg_t;

    chan_cfg_t [1:0]            pend_cfg_q, pend_cfg_d;
    chan_cfg_t [1:0]            act_cfg_q, act_cfg_d;
    logic      [1:0]            ch_en_q, ch_en_d;
    logic      [1:0]            pend_q, pend_d;
    logic      [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic      [1:0][DW-1:0]    dead_q, dead_d;
    logic      [1:0][1:0]       out_q, out_d;
    logic      [31:0]           rdata_q, rdata_d;
    logic      [1:0]            run, wrap, raw;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:CNT_W];

    always_comb begin
        // NOTE: every variable gets a hold-value default up front, so no path can infer a latch.
        pend_cfg_d = pend_cfg_q;
        act_cfg_d  = act_cfg_q;
        ch_en_d    = ch_en_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        dead_d     = dead_q;
        out_d      = out_q;
        rdata_d    = rdata_q;
        run        = '0;
        wrap       = '0;
        raw        = '0;

        // Reads return the shadow (pending) settings, never the active ones.
        if (re) begin
            case (addr)
                3'd0:    rdata_d = {28'd0, pend_cfg_q[1].dir, ch_en_q[1], pend_cfg_q[0].dir, ch_en_q[0]};
                3'd1:    rdata_d = 32'(pend_cfg_q[0].period);
                3'd2:    rdata_d = 32'(pend_cfg_q[0].duty);
                3'd3:    rdata_d = 32'(pend_cfg_q[1].period);
                3'd4:    rdata_d = 32'(pend_cfg_q[1].duty);
                3'd5:    rdata_d = {30'd0, pend_q};
                default: rdata_d = '0;
            endcase
        end

        if (we) begin
            case (addr)
                3'd0: begin
                    ch_en_d           = {wdata[2], wdata[0]};
                    pend_cfg_d[0].dir = wdata[1];
                    pend_cfg_d[1].dir = wdata[3];
                    if (wdata[1] != pend_cfg_q[0].dir) pend_d[0] = 1'b1;
                    if (wdata[3] != pend_cfg_q[1].dir) pend_d[1] = 1'b1;
                end
                3'd1: begin
                    pend_cfg_d[0].period = wdata[CNT_W-1:0];
                    pend_d[0]            = 1'b1;
                end
                3'd2: begin
                    pend_cfg_d[0].duty = wdata[CNT_W-1:0];
                    pend_d[0]          = 1'b1;
                end
                3'd3: begin
                    pend_cfg_d[1].period = wdata[CNT_W-1:0];
                    pend_d[1]            = 1'b1;
                end
                3'd4: begin
                    pend_cfg_d[1].duty = wdata[CNT_W-1:0];
                    pend_d[1]          = 1'b1;
                end
                default: ;
            endcase
        end

        for (int n = 0; n < 2; n++) begin
            run[n]  = ch_en_q[n] && (act_cfg_q[n].period != '0);
            wrap[n] = run[n] && (cnt_q[n] == act_cfg_q[n].period - CNT_W'(1));
            raw[n]  = cnt_q[n] < act_cfg_q[n].duty;

            if (!en) begin
                out_d[n] = 2'b00;
            end else begin
                if (!run[n] || (dead_q[n] != '0)) out_d[n] = 2'b00;
                else if (act_cfg_q[n].dir)        out_d[n] = {raw[n], 1'b0};
                else                              out_d[n] = {1'b0, raw[n]};

                if (wrap[n] && (pend_cfg_d[n].dir != act_cfg_q[n].dir)) dead_d[n] = DEAD_LD;
                else if (dead_q[n] != '0)                               dead_d[n] = dead_q[n] - DW'(1);

                // Loading from the _d shadow forwards a same-cycle write straight into active.
                if (!run[n] || wrap[n]) begin
                    cnt_d[n]     = '0;
                    act_cfg_d[n] = pend_cfg_d[n];
                    pend_d[n]    = 1'b0;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cfg_q <= '0;
            act_cfg_q  <= '0;
            ch_en_q    <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
            dead_q     <= '0;
            out_q      <= '0;
            rdata_q    <= '0;
        end else begin
            pend_cfg_q <= pend_cfg_d;
            act_cfg_q  <= act_cfg_d;
            ch_en_q    <= ch_en_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            dead_q     <= dead_d;
            out_q      <= out_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata   = rdata_q;
    assign pwm1out = out_q[0];
    assign pwm2out = out_q[1];

endmodule

// File: doc/pwm_ctrl.md
Name: pwm_ctrl

Overview:
- Memory-mapped two-channel PWM controller that drives the pwm1out/pwm2out motor-bridge pins of the RV32I multicycle MCU.
- The CPU programs period, duty and direction through word-addressed store/load accesses.
- The block double-buffers the settings and applies them only on a period boundary, so the motors never see glitches.
- On a direction reversal it inserts a dead-time gap so both bridge legs are never driven at once.

Parameters:
- CNT_W, 16, width of period/duty registers and per-channel counters.
- DEAD, 4, dead-time length in clk cycles after a direction change (DEAD ≥ 1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  global run enable; 0 freezes counters and forces outputs low
- we  in  1  bus write strobe, one cycle per access
- re  in  1  bus read strobe
- addr  in  3  word register index
- wdata  in  32  write data
- rdata  out  32  read data, registered
- pwm1out  out  2  channel 1 bridge drive, [0]=forward leg, [1]=reverse leg
- pwm2out  out  2  channel 2 bridge drive, same encoding

Behaviour:
- Register map (addr):
  - 0 CTRL: [0]=en1, [1]=dir1, [2]=en2, [3]=dir2.
  - 1 PERIOD1, 2 DUTY1, 3 PERIOD2, 4 DUTY2: low CNT_W bits used, upper bits ignored.
  - 5 STATUS (read-only): [0]=pend1, [1]=pend2.
  - 6–7 read 0; writes to them are ignored.
- Reset: all pending and active registers, counters, dead counters, pend flags, rdata, pwm1out and pwm2out = 0.
- Writes: on we, the addressed pending register is updated in the same edge. Writing PERIODn, DUTYn, or CTRL with a changed dirn sets pendn.
- Reads: rdata <= register value one cycle after re (1-cycle latency). Pending values are returned, not active ones. rdata holds its value when re=0.
- Counter n, when en=1, enn=1 and active period Pn > 0:
  - cnt increments each cycle.
  - At cnt == Pn-1 (wrap) it returns to 0.
  - On the wrap edge, active period/duty/dir <= pending and pendn clears.
- Channel disabled (enn=0) or Pn == 0:
  - cnt is held at 0, active <= pending every cycle, pendn cleared, output 2'b00.
  - When the channel is re-enabled, counting starts at 0 with the newly loaded settings.
- Write and wrap in the same cycle: the written value is forwarded into active, and pendn ends up 0.
- en=0: counters and dead counters freeze, outputs are 2'b00, and register writes are still accepted. When en returns to 1, everything resumes from the frozen state.
- Raw PWM:
  - pwm = (cnt < Dn).
  - Dn ≥ Pn gives 100% duty; Dn = 0 gives a constant 0.
- Direction drive:
  - dir=0 drives {1'b0, pwm}.
  - dir=1 drives {pwm, 1'b0}.
- Dead time:
  - When the active dir changes at a wrap, the dead counter loads DEAD and the output is forced to 2'b00 while the dead counter ≠ 0.
  - The dead counter decrements each enabled cycle, and the PWM counter keeps running during dead time.
  - A further dir change while the dead counter ≠ 0 reloads it to DEAD.
- Output timing: outputs are registered, so pwmNout reflects the cnt/dead state of the previous cycle (1-cycle latency). Reasserting rst mid-period clears every output to 0 on the next edge.
- Invariant: pwmNout never equals 2'b11.

Test Plan:
- Reset then idle:
  - Hold rst 2 cycles, with en=1 and no writes -> both outputs are 2'b00 and rdata is 0.
  - Read STATUS -> returns 0.
- Basic duty:
  - Write PERIOD1=10, DUTY1=3, CTRL=0x1.
  - Expect pwm1out = 2'b01 for 3 cycles and 2'b00 for 7, repeating every 10 cycles.
  - Expect pwm2out to stay 2'b00 throughout.
- Shadow update:
  - While channel 1 is running (10/3), write DUTY1=8 mid-period -> the current period stays at 3 high cycles, and STATUS[0]=1 until the wrap.
  - The next period shows 8 high cycles, and STATUS[0] reads 0 afterwards.
- Direction reversal with dead time:
  - Set PERIOD1=10, DUTY1=10, then write CTRL=0x3.
  - Expect 2'b01 to persist until the wrap, then exactly 4 cycles of 2'b00, then a constant 2'b10.
  - Assert that 2'b11 is never seen.
- Boundaries:
  - DUTY2=0 gives a constant 2'b00.
  - DUTY2=20 with PERIOD2=5 gives a constant 2'b01.
  - PERIOD2=0 with en2=1 gives 2'b00 with the counter held at 0.
  - A write of DUTY1 on exactly the wrap cycle takes effect immediately.
- Global en freeze:
  - Drop en for 5 cycles mid-period -> outputs are 2'b00 during the freeze.
  - After en returns, the remaining high/low cycle counts of that period are unchanged, and a CTRL write made during the freeze reads back correctly.
